// File: rtl/demux_1to4_stream.sv
// Packet-aware 1:4 stream demultiplexer with one small FIFO per output lane.
// The lane is chosen on the first beat of a packet and held until its last beat.
module demux_1to4_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              sel,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [4*DATA_WIDTH-1:0] out_data,
  output logic [3:0]              out_valid,
  output logic [3:0]              out_last,
  input  logic [3:0]              out_ready,
  output logic                    busy,
  output logic [1:0]              cur_sel
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  typedef enum logic [0:0] {StIdle, StRoute} state_e;

  state_e     state_q, state_d;
  logic [1:0] route_sel_q, route_sel_d;
  logic [1:0] target;
  logic       accept;
  logic [3:0] full, empty, push;

  always_comb begin
    target   = (state_q == StRoute) ? route_sel_q : sel;
    in_ready = !full[target];
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    route_sel_d = route_sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          route_sel_d = sel;
          if (!in_last) state_d = StRoute;
        end
      end
      StRoute: begin
        if (accept && in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      route_sel_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      route_sel_q <= route_sel_d;
    end
  end

  assign busy    = (state_q == StRoute);
  assign cur_sel = route_sel_q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [AW:0]         wptr_q, rptr_q;
    logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
    logic                pop;

    // Extra MSB on the pointers tells full from empty when the index bits match.
    assign empty[k] = (wptr_q == rptr_q);
    assign full[k]  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push[k]  = accept && (target == 2'(k));
    assign pop      = !empty[k] && out_ready[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push[k]) wptr_q <= wptr_q + PtrOne;
        if (pop)     rptr_q <= rptr_q + PtrOne;
      end
    end

    always_ff @(posedge clk) begin
      if (push[k]) mem_q[wptr_q[AW-1:0]] <= {in_last, in_data};
    end

    assign {out_last[k], out_data[k*DATA_WIDTH +: DATA_WIDTH]} = mem_q[rptr_q[AW-1:0]];
    assign out_valid[k] = !empty[k];
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: a reference routing model pushes expected
// beats per lane on input handshakes; lane pops are compared against the queue heads.
module tb_demux_1to4_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sel = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_last;
  logic [3:0]    ordy = 4'hF;
  logic          busy;
  logic [1:0]    cur_sel;

  demux_1to4_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(ordy),
    .busy     (busy),
    .cur_sel  (cur_sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected lane contents plus the routing FSM.
  bit [DW:0] q [4][$];
  bit        m_busy = 1'b0;
  bit [1:0]  m_route = 2'd0;
  int        pops [4] = '{0, 0, 0, 0};

  task automatic model_clear();
    for (int k = 0; k < 4; k++) q[k].delete();
    m_busy  = 1'b0;
    m_route = 2'd0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      automatic bit [1:0] tgt = m_busy ? m_route : sel;
      automatic bit       rdy = (q[tgt].size() < DEPTH);
      automatic bit [DW:0] e;
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_busy) check("cur_sel", 32'(cur_sel), 32'(m_route));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
        if (out_valid[k] && ordy[k] && q[k].size() != 0) begin
          e = q[k].pop_front();
          check($sformatf("lane%0d_data", k), 32'(out_data[k*DW +: DW]), 32'(e[DW-1:0]));
          check($sformatf("lane%0d_last", k), 32'(out_last[k]), 32'(e[DW]));
          pops[k]++;
        end
      end
      if (in_valid && rdy) begin
        q[tgt].push_back({in_last, in_data});
        if (!m_busy) begin
          m_route = sel;
          m_busy  = !in_last;
        end else if (in_last) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
    sel      = s;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    int base;
    bit drained;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cur_sel", 32'(cur_sel), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // Single-beat packet to lane 2.
    ordy = 4'hF;
    send(2'd2, 8'hA5, 1'b1);
    check("single_valid", 32'(out_valid), 32'h4);
    check("single_data", 32'(out_data[2*DW +: DW]), 32'hA5);
    check("single_last", 32'(out_last[2]), 32'h1);
    check("single_busy", 32'(busy), 32'h0);

    // Three-beat packet; sel changes mid-packet must be ignored.
    send(2'd1, 8'h11, 1'b0);
    check("pkt_busy1", 32'(busy), 32'h1);
    check("pkt_cur_sel", 32'(cur_sel), 32'h1);
    send(2'd3, 8'h22, 1'b0);
    send(2'd0, 8'h33, 1'b1);
    check("pkt_busy_end", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure on lane 0.
    ordy = 4'b1110;
    send(2'd0, 8'h01, 1'b0);
    send(2'd0, 8'h02, 1'b0);
    check("bp_full_ready", 32'(in_ready), 32'h0);
    sel = 2'd3; in_data = 8'h03; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_block", 32'(in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    ordy = 4'hF;
    wait_accept();
    check("bp_busy_end", 32'(busy), 32'h0);
    send(2'd3, 8'h04, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Concurrent drain of all lanes.
    ordy = 4'h0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send(2'(k), 8'(8'h40 + k * 16 + i), 1'b1);
    check("drain_loaded", 32'(out_valid), 32'hF);
    ordy = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(out_valid), 32'h0);

    // Reset in the middle of a packet to lane 2.
    ordy = 4'h0;
    send(2'd2, 8'hA1, 1'b0);
    send(2'd2, 8'hA2, 1'b0);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ordy = 4'hF;
    send(2'd0, 8'h77, 1'b1);
    check("post_rst_lane0", 32'(out_valid), 32'h1);
    repeat (3) @(posedge clk);
    #1;

    // Pointer wrap with a toggling consumer on lane 1.
    base = pops[1];
    ordy = 4'b1101;
    fork
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          ordy[1] = ~ordy[1];
        end
      end
      begin
        for (int i = 0; i < 10; i++) send(2'd1, 8'(8'h50 + i), 1'b1);
      end
    join
    ordy = 4'hF;
    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("final_drained", 32'(drained), 32'h1);
    check("wrap_count", 32'(pops[1] - base), 32'd10);
    check("final_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
